// File: rtl/control_unit.sv
// control_unit: multicycle RISC-V style main controller.
// A Moore FSM sequences each instruction through its datapath steps; the ALU
// decoder, immediate-format decoder and PC write enable are combinational
// helpers layered on top of the state outputs.
module control_unit (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] OP,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUControl,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    ALUWB    = 4'd7,
    EXECI    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;

  state_t     state_r;
  state_t     state_next_s;
  logic [1:0] alu_op_s;
  logic       pc_update_s;
  logic       branch_s;

  // State register; reset pulls the FSM back to FETCH at any time, even mid-instruction.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; only the opcode steers branching so funct fields cannot disturb sequencing.
  always_comb begin
    state_next_s = FETCH;
    case (state_r)
      FETCH: state_next_s = DECODE;
      DECODE: begin
        if ((OP == OP_LW) || (OP == OP_SW)) begin
          state_next_s = MEMADR;
        end else if (OP == OP_R) begin
          state_next_s = EXECR;
        end else if (OP == OP_I) begin
          state_next_s = EXECI;
        end else if (OP == OP_JAL) begin
          state_next_s = JAL;
        end else if (OP == OP_BEQ) begin
          state_next_s = BEQ;
        end else begin
          state_next_s = FETCH;
        end
      end
      MEMADR: begin
        if (OP == OP_LW) begin
          state_next_s = MEMREAD;
        end else begin
          state_next_s = MEMWRITE;
        end
      end
      MEMREAD:  state_next_s = MEMWB;
      EXECR:    state_next_s = ALUWB;
      EXECI:    state_next_s = ALUWB;
      JAL:      state_next_s = ALUWB;
      MEMWB:    state_next_s = FETCH;
      MEMWRITE: state_next_s = FETCH;
      ALUWB:    state_next_s = FETCH;
      BEQ:      state_next_s = FETCH;
      default:  state_next_s = FETCH;
    endcase
  end

  // Moore state outputs; everything not driven by a state stays 0, including the unused encodings.
  always_comb begin
    AdrSrc      = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    RegWrite    = 1'b0;
    alu_op_s    = 2'b00;
    pc_update_s = 1'b0;
    branch_s    = 1'b0;
    case (state_r)
      FETCH: begin
        IRWrite     = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        pc_update_s = 1'b1;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXECR: begin
        ALUSrcA  = 2'b10;
        alu_op_s = 2'b10;
      end
      ALUWB: begin
        RegWrite = 1'b1;
      end
      EXECI: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b01;
        alu_op_s = 2'b10;
      end
      JAL: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        pc_update_s = 1'b1;
      end
      BEQ: begin
        ALUSrcA  = 2'b10;
        alu_op_s = 2'b01;
        branch_s = 1'b1;
      end
      default: begin
        AdrSrc = 1'b0;
      end
    endcase
  end

  // PC write enable; Zero only matters while a branch is being resolved.
  always_comb begin
    PCWrite = pc_update_s | (branch_s & Zero);
  end

  // Immediate format follows the opcode directly.
  always_comb begin
    ImmSrc = 2'b00;
    case (OP)
      OP_LW:   ImmSrc = 2'b00;
      OP_I:    ImmSrc = 2'b00;
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // ALU decoder; subtract for R-type only when both OP[5] and funct7 flag it.
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op_s)
      2'b00: ALUControl = 3'b000;
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000: begin
            if (OP[5] & funct7) begin
              ALUControl = 3'b001;
            end else begin
              ALUControl = 3'b000;
            end
          end
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized instruction streams against an instruction-step
// model of the controller, plus directed lw/beq sequences with literal words
// and asynchronous reset checks.
module tb_control_unit;

  logic       CLK = 1'b0;
  logic       RST;
  logic [6:0] OP;
  logic [2:0] funct3;
  logic       funct7;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  int vectors = 0;
  int miscompares = 0;

  control_unit dut (
    .CLK(CLK), .RST(RST), .OP(OP), .funct3(funct3), .funct7(funct7), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUControl(ALUControl), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite)
  );

  always #5 CLK = ~CLK;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;

  // Instruction steps, named by what the datapath is doing.
  typedef enum int {S_FETCH, S_DECODE, S_ADDR, S_LOAD, S_LOADWB, S_STORE,
                    S_RALU, S_IALU, S_LINK, S_BRANCH, S_WB} step_t;
  step_t step;

  // Which step comes after the current one, given the opcode visible on this edge.
  function automatic step_t model_next(step_t s, logic [6:0] op);
    step_t n = S_FETCH;
    case (s)
      S_FETCH:  n = S_DECODE;
      S_DECODE: n = (op == LW || op == SW) ? S_ADDR : (op == RT) ? S_RALU :
                    (op == IT) ? S_IALU : (op == JL) ? S_LINK : (op == BQ) ? S_BRANCH : S_FETCH;
      S_ADDR:   n = (op == LW) ? S_LOAD : S_STORE;
      S_LOAD:   n = S_LOADWB;
      S_RALU, S_IALU, S_LINK: n = S_WB;
      default:  n = S_FETCH;
    endcase
    return n;
  endfunction

  // Expected control word {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUControl,ALUSrcA,ALUSrcB,ImmSrc,RegWrite}.
  function automatic logic [16:0] model_word(step_t s, logic [6:0] op, logic [2:0] f3, logic f7, logic z);
    int pcw = 0, adr = 0, mw = 0, irw = 0, res = 0, srca = 0, srcb = 0, imm = 0, rw = 0, aop = 0, aluc = 0;
    case (s)
      S_FETCH:  begin irw = 1; srcb = 2; res = 2; pcw = 1; end
      S_DECODE: begin srca = 1; srcb = 1; end
      S_ADDR:   begin srca = 2; srcb = 1; end
      S_LOAD:   adr = 1;
      S_LOADWB: begin res = 1; rw = 1; end
      S_STORE:  begin adr = 1; mw = 1; end
      S_RALU:   begin srca = 2; aop = 2; end
      S_IALU:   begin srca = 2; srcb = 1; aop = 2; end
      S_LINK:   begin srca = 1; srcb = 2; pcw = 1; end
      S_BRANCH: begin srca = 2; aop = 1; pcw = z ? 1 : 0; end
      S_WB:     rw = 1;
      default:  rw = 0;
    endcase
    if (aop == 1) aluc = 1;
    else if (aop == 2) begin
      if (f3 == 3'd0) aluc = (op[5] && f7) ? 1 : 0;
      else if (f3 == 3'd2) aluc = 5;
      else if (f3 == 3'd6) aluc = 3;
      else if (f3 == 3'd7) aluc = 2;
      else aluc = 0;
    end
    imm = (op == SW) ? 1 : (op == BQ) ? 2 : (op == JL) ? 3 : 0;
    return {pcw[0], adr[0], mw[0], irw[0], res[1:0], aluc[2:0], srca[1:0], srcb[1:0], imm[1:0], rw[0]};
  endfunction

  // Single comparison point for every checked output word.
  task automatic check(input string name, input logic [16:0] exp);
    logic [16:0] got;
    got = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl, ALUSrcA, ALUSrcB, ImmSrc, RegWrite};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s step=%s op=%b: got %b expected %b", name, step.name(), OP, got, exp);
    end
  endtask

  // One clock cycle: drive inputs at negedge, compare, then advance the model on posedge.
  task automatic cycle(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z,
                       input bit use_lit, input logic [16:0] lit, input bit do_rst);
    @(negedge CLK);
    RST = 1'b0;
    OP = op; funct3 = f3; funct7 = f7; Zero = z;
    #1;
    check("model", model_word(step, OP, funct3, funct7, Zero));
    if (use_lit) check("literal", lit);
    if (do_rst) begin
      #1 RST = 1'b1;
      #1;
      step = S_FETCH;
      check("async_rst", model_word(step, OP, funct3, funct7, Zero));
      @(posedge CLK);
      #1 check("rst_hold", model_word(step, OP, funct3, funct7, Zero));
    end else begin
      @(posedge CLK);
      step = model_next(step, OP);
    end
  endtask

  logic [6:0] ops [6];
  logic [6:0] cur_op;

  initial begin
    ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = IT; ops[4] = JL; ops[5] = BQ;
    RST = 1'b1; OP = LW; funct3 = 3'b010; funct7 = 1'b0; Zero = 1'b0;
    step = S_FETCH;
    #1;
    check("reset_lit", 17'b1_0_0_1_10_000_00_10_00_0);
    check("reset_model", model_word(step, OP, funct3, funct7, Zero));
    #20;

    // lw after reset: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH.
    cycle(LW, 3'b010, 1'b0, 1'b0, 1'b1, 17'b1_0_0_1_10_000_00_10_00_0, 1'b0);
    cycle(LW, 3'b010, 1'b0, 1'b1, 1'b1, 17'b0_0_0_0_00_000_01_01_00_0, 1'b0);
    cycle(LW, 3'b010, 1'b0, 1'b1, 1'b1, 17'b0_0_0_0_00_000_10_01_00_0, 1'b0);
    cycle(LW, 3'b010, 1'b0, 1'b1, 1'b1, 17'b0_1_0_0_00_000_00_00_00_0, 1'b0);
    cycle(LW, 3'b010, 1'b0, 1'b1, 1'b1, 17'b0_0_0_0_01_000_00_00_00_1, 1'b0);
    // beq taken: FETCH, DECODE, BEQ with PCWrite from Zero.
    cycle(BQ, 3'b000, 1'b0, 1'b1, 1'b1, 17'b1_0_0_1_10_000_00_10_10_0, 1'b0);
    cycle(BQ, 3'b000, 1'b0, 1'b1, 1'b1, 17'b0_0_0_0_00_000_01_01_10_0, 1'b0);
    cycle(BQ, 3'b000, 1'b0, 1'b1, 1'b1, 17'b1_0_0_0_00_001_10_00_10_0, 1'b0);
    // R-type or: EXECR ALUControl=011, then ALUWB.
    cycle(RT, 3'b110, 1'b1, 1'b0, 1'b1, 17'b1_0_0_1_10_000_00_10_00_0, 1'b0);
    cycle(RT, 3'b110, 1'b1, 1'b0, 1'b0, 17'b0, 1'b0);
    cycle(RT, 3'b110, 1'b1, 1'b0, 1'b1, 17'b0_0_0_0_00_011_10_00_00_0, 1'b0);
    cycle(RT, 3'b110, 1'b1, 1'b0, 1'b1, 17'b0_0_0_0_00_000_00_00_00_1, 1'b0);
    // lw interrupted in MEMREAD: reset forces FETCH, no write-back.
    cycle(LW, 3'b000, 1'b0, 1'b0, 1'b0, 17'b0, 1'b0);
    cycle(LW, 3'b000, 1'b0, 1'b0, 1'b0, 17'b0, 1'b0);
    cycle(LW, 3'b000, 1'b0, 1'b0, 1'b0, 17'b0, 1'b0);
    cycle(LW, 3'b000, 1'b0, 1'b0, 1'b1, 17'b0_1_0_0_00_000_00_00_00_0, 1'b1);
    cycle(LW, 3'b000, 1'b0, 1'b0, 1'b1, 17'b1_0_0_1_10_000_00_10_00_0, 1'b0);

    // Randomized instruction stream with occasional opcode glitches and resets.
    cur_op = LW;
    for (int i = 0; i < 4000; i++) begin
      logic [6:0] op_now;
      if (step == S_FETCH) begin
        if ($urandom_range(0, 7) == 0) cur_op = 7'($urandom);
        else cur_op = ops[$urandom_range(0, 5)];
      end
      op_now = ($urandom_range(0, 15) == 0) ? 7'($urandom) : cur_op;
      cycle(op_now, 3'($urandom), 1'($urandom), 1'($urandom), 1'b0, 17'b0,
            ($urandom_range(0, 59) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
